// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage.
// Holds the PC and fetches one 32-bit word per instruction over a req/ack
// memory port. The fetched word is latched in the instruction register (IR).
// When the instruction retires, the next PC is computed from branch/jump/zero.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   imem_req     : instruction read request (registered)
//   imem_addr    : read address, equal to the PC and held while imem_req=1
//   imem_rdata   : read data, valid together with imem_ack
//   imem_ack     : read complete; only looked at while imem_req=1
//   instr_done   : one-cycle retire pulse from the datapath
//   branch, jump : control-unit decisions, sampled with instr_done
//   zero         : ALU zero flag, sampled with instr_done
//   instr        : IR contents
//   op_out       : IR[31:26], the opcode
//   func_out     : IR[5:0], the funct field
//   instr_valid  : IR holds a fetched instruction that has not retired yet
//   pc_out       : address of the instruction in IR
//   pc_plus4     : pc_out + 4, modulo 2^32
//   fetch_err    : sticky ack-timeout fault, cleared only by reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        instr_done,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] instr,
  output logic [5:0]  op_out,
  output logic [5:0]  func_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pc_plus4_q;
  logic [31:0]        ir_q, ir_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]        jump_target;
  logic [31:0]        branch_target;

  // Retire-time targets, formed from the registered PC+4 and IR.
  assign jump_target   = {pc_plus4_q[31:28], ir_q[25:0], 2'b00};
  assign branch_target = pc_plus4_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
      ir_q       <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_d + 32'd4;
      ir_q       <= ir_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      FETCH: begin
        if (!req_q) begin
          // First cycle after reset release: raise the request.
          req_d = 1'b1;
          cnt_d = '0;
        end else if (imem_ack) begin
          ir_d    = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // This is the ACK_TIMEOUT-th request cycle without an ack.
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = FAULT;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end

      HOLD: begin
        valid_d = 1'b1;
        if (instr_done) begin
          if (jump) begin
            pc_d = jump_target;
          end else if (branch && zero) begin
            pc_d = branch_target;
          end else begin
            pc_d = pc_plus4_q;
          end
          valid_d = 1'b0;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end

      FAULT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end

      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = ir_q;
  assign op_out      = ir_q[31:26];
  assign func_out    = ir_q[5:0];
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Two instances share every input and
// run in lockstep: u_dut uses the default reset PC, u_dut_hi starts at
// 0x4000_0020 so that the jump case sees a non-zero upper PC nibble.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        instr_done;
  logic        branch;
  logic        jump;
  logic        zero;

  logic        imem_req,    imem_req_hi;
  logic [31:0] imem_addr,   imem_addr_hi;
  logic [31:0] instr,       instr_hi;
  logic [5:0]  op_out,      op_out_hi;
  logic [5:0]  func_out,    func_out_hi;
  logic        instr_valid, instr_valid_hi;
  logic [31:0] pc_out,      pc_out_hi;
  logic [31:0] pc_plus4,    pc_plus4_hi;
  logic        fetch_err,   fetch_err_hi;

  int n_vec;
  int n_err;

  instr_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .ACK_TIMEOUT (16)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instr_done  (instr_done),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .instr       (instr),
    .op_out      (op_out),
    .func_out    (func_out),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  instr_fetch_unit #(
    .RESET_PC    (32'h4000_0020),
    .ACK_TIMEOUT (16)
  ) u_dut_hi (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req_hi),
    .imem_addr   (imem_addr_hi),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instr_done  (instr_done),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .instr       (instr_hi),
    .op_out      (op_out_hi),
    .func_out    (func_out_hi),
    .instr_valid (instr_valid_hi),
    .pc_out      (pc_out_hi),
    .pc_plus4    (pc_plus4_hi),
    .fetch_err   (fetch_err_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold ack low for wait_n request cycles, then return data with ack.
  task automatic do_fetch(input int wait_n, input logic [31:0] data);
    imem_ack = 1'b0;
    repeat (wait_n) tick();
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  // One-cycle retire pulse with the given control decisions.
  task automatic retire(input logic br, input logic jmp, input logic zr);
    instr_done = 1'b1;
    branch     = br;
    jump       = jmp;
    zero       = zr;
    tick();
    instr_done = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    zero       = 1'b0;
  endtask

  // Reset both instances and let the first request come up.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    imem_rdata = '0;
    imem_ack   = 1'b0;
    instr_done = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    zero       = 1'b0;

    // T1: reset values, first request, async drop of a live request.
    repeat (3) tick();
    check_eq("rst_req",   32'(imem_req),    32'd0);
    check_eq("rst_addr",  imem_addr,        32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_err",   32'(fetch_err),   32'd0);
    check_eq("rst_ir",    instr,            32'h0);
    check_eq("rst_pc4",   pc_plus4,         32'h4);
    rst_n = 1'b1;
    tick();
    check_eq("rel_req",   32'(imem_req),    32'd1);
    check_eq("rel_addr",  imem_addr,        32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("async_req_drop", 32'(imem_req), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rel2_req", 32'(imem_req), 32'd1);

    // T2: add fetched after 3 wait cycles, sequential retire.
    do_fetch(3, 32'h012A_4020);
    check_eq("add_valid", 32'(instr_valid), 32'd1);
    check_eq("add_ir",    instr,            32'h012A_4020);
    check_eq("add_op",    32'(op_out),      32'h00);
    check_eq("add_func",  32'(func_out),    32'h20);
    check_eq("add_req",   32'(imem_req),    32'd0);
    check_eq("add_pc",    pc_out,           32'h0);
    // Ack while no request is pending must not disturb the held IR.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check_eq("stray_ack_ir", instr, 32'h012A_4020);
    retire(1'b0, 1'b0, 1'b0);
    check_eq("seq_addr",  imem_addr,        32'h4);
    check_eq("seq_req",   32'(imem_req),    32'd1);
    check_eq("seq_valid", 32'(instr_valid), 32'd0);

    // Walk to pc=0x10 with NOPs.
    do_fetch(0, 32'h0); retire(1'b0, 1'b0, 1'b0);
    do_fetch(1, 32'h0); retire(1'b0, 1'b0, 1'b0);
    do_fetch(0, 32'h0); retire(1'b0, 1'b0, 1'b0);
    check_eq("walk_addr", imem_addr, 32'h10);

    // T3: beq at 0x10 with offset -2 words, taken then not taken.
    do_fetch(0, 32'h1109_FFFE);
    check_eq("beq_op",  32'(op_out), 32'h04);
    check_eq("beq_pc4", pc_plus4,    32'h14);
    retire(1'b1, 1'b0, 1'b1);
    check_eq("beq_taken", imem_addr, 32'h0C);
    do_fetch(0, 32'h0); retire(1'b0, 1'b0, 1'b0);
    do_fetch(2, 32'h1109_FFFE);
    retire(1'b1, 1'b0, 1'b0);
    check_eq("beq_not_taken", imem_addr, 32'h14);

    // Retire pulse during FETCH is ignored.
    instr_done = 1'b1;
    jump       = 1'b1;
    tick();
    instr_done = 1'b0;
    jump       = 1'b0;
    check_eq("done_in_fetch_addr", imem_addr,     32'h14);
    check_eq("done_in_fetch_req",  32'(imem_req), 32'd1);

    // T4: jump wins over branch; upper nibble from pc+4.
    do_reset();
    check_eq("hi_rst_addr", imem_addr_hi, 32'h4000_0020);
    do_fetch(0, 32'h0800_0100);
    check_eq("hi_pc4", pc_plus4_hi, 32'h4000_0024);
    retire(1'b1, 1'b1, 1'b1);
    check_eq("jump_hi_addr", imem_addr_hi, 32'h4000_0400);
    check_eq("jump_lo_addr", imem_addr,    32'h0000_0400);

    // T6: branch back from 0 wraps to 0xFFFFFFFC, then sequential wraps to 0.
    do_reset();
    do_fetch(0, 32'h1000_FFFE);
    retire(1'b1, 1'b0, 1'b1);
    check_eq("wrap_back_addr", imem_addr, 32'hFFFF_FFFC);
    do_fetch(0, 32'h0);
    check_eq("wrap_pc4", pc_plus4,        32'h0);
    check_eq("nop_op",   32'(op_out),     32'h0);
    retire(1'b0, 1'b0, 1'b0);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // T5: 16 request cycles without ack raise the sticky fault.
    repeat (15) tick();
    check_eq("to_req_pre", 32'(imem_req),  32'd1);
    check_eq("to_err_pre", 32'(fetch_err), 32'd0);
    tick();
    check_eq("to_err",     32'(fetch_err), 32'd1);
    check_eq("to_req",     32'(imem_req),  32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack   = 1'b0;
    retire(1'b0, 1'b1, 1'b0);
    tick();
    check_eq("fault_err",   32'(fetch_err),   32'd1);
    check_eq("fault_req",   32'(imem_req),    32'd0);
    check_eq("fault_valid", 32'(instr_valid), 32'd0);
    check_eq("fault_addr",  imem_addr,        32'h0);
    check_eq("fault_ir",    instr,            32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("fault_clear", 32'(fetch_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_fault_req", 32'(imem_req), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
